// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
//   Memory-mapped cycle timer with reload, sticky overflow status and a
//   three-state interrupt sequencer that drives the CPU irq input.
//
//   Register map (full 32-bit byte-address compare against BASE):
//     BASE+0x0  TH    reload value, R/W
//     BASE+0x4  TL    counter, R/W
//     BASE+0x8  TCON  bit0 EN (R/W), bit1 IE (R/W), bit2 ST (R, W1C)
//     BASE+0xC  OVC   overflow count, read-only, wraps
//
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous, active-low reset
//     rd, wr     peripheral read / write strobes
//     addr       byte address
//     wdata      write data
//     rdata      combinational read data (0 unless rd and a decoded address)
//     pc_kernel  PC[31] of the current instruction
//     irq_taken  one-cycle pulse when the CPU vectors to the handler
//     irq        interrupt request
//     state      current sequencer state (IDLE=0, PEND=1, SERV=2)
//
//   Bus handshake: rd and wr are single-cycle qualifiers with no
//   backpressure; a write is accepted in the cycle wr=1 and takes effect at
//   the following rising edge, a read returns data combinationally in the
//   same cycle rd=1.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        pc_kernel,
  input  logic        irq_taken,
  output logic        irq,
  output logic [1:0]  state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  logic [31:0] th;
  logic [31:0] tl;
  logic [31:0] ovc;
  logic        en;
  logic        ie;
  logic        st;
  logic [1:0]  s;
  logic [1:0]  s_next;

  logic wr_th;
  logic wr_tl;
  logic wr_tcon;
  logic tl_max;
  logic ovf;
  logic ovf_event;

  assign wr_th   = wr && (addr == BASE);
  assign wr_tl   = wr && (addr == BASE + 32'h4);
  assign wr_tcon = wr && (addr == BASE + 32'h8);
  assign tl_max  = (tl == 32'hFFFF_FFFF);

  // A write that clears EN in the overflow cycle cancels the overflow: no
  // reload and no status set, TL simply holds at all-ones.
  assign ovf = en && tl_max && !(wr_tcon && !wdata[0]);
  // A bus write to TL in the overflow cycle wins and also suppresses the
  // status/count side effects of that overflow.
  assign ovf_event = ovf && !wr_tl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th  <= '0;
      tl  <= '0;
      ovc <= '0;
      en  <= 1'b0;
      ie  <= 1'b0;
      st  <= 1'b0;
    end else begin
      if (wr_th) th <= wdata;

      // Reload uses the TH value from before this edge, so a TH write in
      // the overflow cycle only affects the next overflow.
      if (wr_tl)                 tl <= wdata;
      else if (ovf)              tl <= th;
      else if (en && !tl_max)    tl <= tl + 32'd1;

      if (wr_tcon) begin
        en <= wdata[0];
        ie <= wdata[1];
      end

      // A new overflow beats a simultaneous write-one-to-clear.
      if (ovf_event)                 st <= 1'b1;
      else if (wr_tcon && wdata[2])  st <= 1'b0;

      if (ovf_event) ovc <= ovc + 32'd1;
    end
  end

  always_comb begin
    s_next = s;
    case (s)
      S_IDLE: if (st && ie) s_next = S_PEND;
      S_PEND: begin
        if (irq_taken)       s_next = S_SERV;
        else if (!st || !ie) s_next = S_IDLE;
      end
      // Leave service only once the handler has acknowledged the status
      // and returned to user mode, so the request cannot re-enter.
      S_SERV: if (!st && !pc_kernel) s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s <= S_IDLE;
    else        s <= s_next;
  end

  // Kernel mode masks the request combinationally without dropping PEND.
  assign irq   = (s == S_PEND) && !pc_kernel;
  assign state = s;

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        BASE:          rdata = th;
        BASE + 32'h4:  rdata = tl;
        BASE + 32'h8:  rdata = {29'd0, st, ie, en};
        BASE + 32'hC:  rdata = ovc;
        default:       rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl
//   Directed bench for timer_irq_ctrl: reload/interrupt, handshake, kernel
//   masking, collisions, address decode and reset during a pending request.
module tb_timer_irq_ctrl;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE;
  localparam logic [31:0] A_TL   = BASE + 32'h4;
  localparam logic [31:0] A_TCON = BASE + 32'h8;
  localparam logic [31:0] A_OVC  = BASE + 32'hC;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_PEND = 32'd1;
  localparam logic [31:0] ST_SERV = 32'd2;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        pc_kernel;
  logic        irq_taken;
  logic        irq;
  logic [1:0]  state;

  int n_checks;
  int n_fail;

  timer_irq_ctrl #(.BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .pc_kernel (pc_kernel),
    .irq_taken (irq_taken),
    .irq       (irq),
    .state     (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    cyc();
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd   = 1'b1;
    addr = a;
    #1;
    chk(tag, rdata, exp);
    rd   = 1'b0;
    addr = '0;
  endtask

  task automatic chk_irq(input string tag, input logic exp_irq, input logic [31:0] exp_state);
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    chk({tag, "_state"}, {30'd0, state}, exp_state);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    rd        = 1'b0;
    wr        = 1'b0;
    addr      = '0;
    wdata     = '0;
    pc_kernel = 1'b0;
    irq_taken = 1'b0;
    #2 reset = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk_irq("rst", 1'b0, ST_IDLE);
    chk("rst_rdata_idle", rdata, 32'd0);
    read_chk("rst_th", A_TH, 32'd0);
    read_chk("rst_tl", A_TL, 32'd0);
    read_chk("rst_tcon", A_TCON, 32'd0);
    read_chk("rst_ovc", A_OVC, 32'd0);
    reset = 1'b1;
    cyc();

    // Reload and interrupt
    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    read_chk("rl_tl0", A_TL, 32'hFFFF_FFFE);
    read_chk("rl_tcon0", A_TCON, 32'h3);
    cyc();
    read_chk("rl_tl1", A_TL, 32'hFFFF_FFFF);
    cyc();
    read_chk("rl_tl_reload", A_TL, 32'hFFFF_FFFC);
    read_chk("rl_tcon_st", A_TCON, 32'h7);
    read_chk("rl_ovc", A_OVC, 32'd1);
    chk_irq("rl_pre", 1'b0, ST_IDLE);
    cyc();
    chk_irq("rl_pend", 1'b1, ST_PEND);

    // Handshake: freeze counter, take irq in kernel mode, ack, return
    bus_write(A_TCON, 32'h2);
    read_chk("hs_tl_hold", A_TL, 32'hFFFF_FFFE);
    bus_write(A_TL, 32'd0);
    bus_write(A_TH, 32'd0);
    chk_irq("hs_still_pend", 1'b1, ST_PEND);
    irq_taken = 1'b1;
    cyc();
    irq_taken = 1'b0;
    pc_kernel = 1'b1;
    chk_irq("hs_serv", 1'b0, ST_SERV);
    cyc();
    bus_write(A_TCON, 32'h7);
    read_chk("hs_tcon_w1c", A_TCON, 32'h3);
    cyc();
    chk_irq("hs_serv_kernel", 1'b0, ST_SERV);
    pc_kernel = 1'b0;
    cyc();
    chk_irq("hs_idle", 1'b0, ST_IDLE);
    cyc();
    chk_irq("hs_no_reassert", 1'b0, ST_IDLE);
    irq_taken = 1'b1;
    cyc();
    irq_taken = 1'b0;
    chk_irq("hs_taken_in_idle", 1'b0, ST_IDLE);

    // Kernel masking
    bus_write(A_TCON, 32'h0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    pc_kernel = 1'b1;
    bus_write(A_TCON, 32'h3);
    cyc();
    read_chk("km_ovc", A_OVC, 32'd2);
    read_chk("km_tcon", A_TCON, 32'h7);
    cyc();
    chk("km_state_pend", {30'd0, state}, ST_PEND);
    for (int i = 0; i < 10; i++) begin
      chk("km_masked", {31'd0, irq}, 32'd0);
      cyc();
    end
    pc_kernel = 1'b0;
    #1;
    chk_irq("km_unmask", 1'b1, ST_PEND);
    irq_taken = 1'b1;
    cyc();
    irq_taken = 1'b0;
    chk_irq("km_serv", 1'b0, ST_SERV);
    bus_write(A_TCON, 32'h4);
    cyc();
    chk_irq("km_idle", 1'b0, ST_IDLE);

    // Collision: TL write in the overflow cycle
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h1);
    cyc();
    bus_write(A_TL, 32'd5);
    read_chk("col_tl_wins", A_TL, 32'd5);
    read_chk("col_tl_st", A_TCON, 32'h1);
    read_chk("col_tl_ovc", A_OVC, 32'd2);

    // Collision: W1C of ST with a new overflow
    bus_write(A_TL, 32'hFFFF_FFFE);
    cyc();
    cyc();
    read_chk("col_w1c_pre_st", A_TCON, 32'h5);
    read_chk("col_w1c_pre_ovc", A_OVC, 32'd3);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h5);
    read_chk("col_w1c_st", A_TCON, 32'h5);
    read_chk("col_w1c_ovc", A_OVC, 32'd4);
    read_chk("col_w1c_tl", A_TL, 32'd0);

    // Collision: EN cleared in the overflow cycle
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h4);
    read_chk("col_en_tl", A_TL, 32'hFFFF_FFFF);
    read_chk("col_en_tcon", A_TCON, 32'h0);
    read_chk("col_en_ovc", A_OVC, 32'd4);

    // Collision: TH write in the overflow cycle
    bus_write(A_TCON, 32'h1);
    bus_write(A_TH, 32'h100);
    read_chk("col_th_tl", A_TL, 32'd0);
    read_chk("col_th_th", A_TH, 32'h100);
    read_chk("col_th_tcon", A_TCON, 32'h5);
    read_chk("col_th_ovc", A_OVC, 32'd5);

    // PEND falls back to IDLE when IE is cleared before irq_taken
    bus_write(A_TCON, 32'h3);
    cyc();
    chk_irq("ie_pend", 1'b1, ST_PEND);
    bus_write(A_TCON, 32'h1);
    cyc();
    chk_irq("ie_idle", 1'b0, ST_IDLE);
    bus_write(A_TCON, 32'h4);

    // Decode
    bus_write(BASE + 32'h10, 32'hDEAD_BEEF);
    bus_write(32'hC000_0008, 32'h3);
    bus_write(32'h0000_0008, 32'h3);
    read_chk("dec_rd_10", BASE + 32'h10, 32'd0);
    read_chk("dec_rd_upper", 32'hC000_0008, 32'd0);
    read_chk("dec_rd_low", 32'h0000_0008, 32'd0);
    read_chk("dec_tcon", A_TCON, 32'd0);
    read_chk("dec_th", A_TH, 32'h100);
    read_chk("dec_tl", A_TL, 32'd5);
    read_chk("dec_ovc", A_OVC, 32'd5);
    addr = A_TL;
    #1;
    chk("dec_no_rd", rdata, 32'd0);
    addr = '0;

    // Reset during PEND
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h3);
    cyc();
    read_chk("rp_ovc", A_OVC, 32'd6);
    read_chk("rp_tl", A_TL, 32'h100);
    cyc();
    chk_irq("rp_pend", 1'b1, ST_PEND);
    reset = 1'b0;
    #1;
    chk_irq("rp_async", 1'b0, ST_IDLE);
    read_chk("rp_th", A_TH, 32'd0);
    read_chk("rp_tl0", A_TL, 32'd0);
    read_chk("rp_tcon", A_TCON, 32'd0);
    read_chk("rp_ovc0", A_OVC, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    chk_irq("rp_after", 1'b0, ST_IDLE);
    read_chk("rp_after_tl", A_TL, 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Memory-mapped timer and interrupt sequencer on the CPU peripheral bus (peripheral space selected by ALU address bit 30). It counts clock cycles, reloads on overflow, latches an interrupt status bit and drives the CPU `irq` input through a three-state handshake. The handshake keeps the request from re-entering while the CPU runs in kernel mode (PC[31] = 1). This block replaces the current constant-zero IRQ source.

## Interface

- `BASE`, 32'h4000_0000, byte address of the first register; registers sit at BASE+0x0/0x4/0x8/0xC.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd`  in  1  peripheral read strobe.
- `wr`  in  1  peripheral write strobe (CPU PerWr).
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  write data (register-file port B).
- `rdata`  out  32  read data; combinational.
- `pc_kernel`  in  1  PC[31] of the current instruction.
- `irq_taken`  in  1  one-cycle pulse from the CPU in the cycle it selects the ILLOP vector.
- `irq`  out  1  interrupt request to Control.

## Operation

- **Registers** (full 32-bit address compare; all other addresses: writes ignored, `rdata` = 0).
  - TH @BASE+0x0: reload value, R/W.
  - TL @BASE+0x4: counter, R/W.
  - TCON @BASE+0x8:
    - bit0 EN, R/W.
    - bit1 IE, R/W.
    - bit2 ST, read; a write of 1 clears it (W1C).
    - bits 31:3 read as 0.
  - OVC @BASE+0xC: overflow count, read-only, 32-bit, wraps at 2^32.
- **Counter**
  - While EN=1, TL increments by 1 every cycle.
  - When TL = 32'hFFFF_FFFF and EN=1: the next TL is TH, ST is set to 1, and OVC increments.
  - While EN=0, TL holds.
- **Read**: `rdata` = selected register when `rd`=1 and the address matches; otherwise 0.
- **FSM**, state `s`, three states:
  - IDLE → PEND when ST=1 and IE=1.
  - PEND: `irq` = ~`pc_kernel`. On `irq_taken` → SERV. If ST or IE is cleared before `irq_taken` → IDLE.
  - SERV: `irq` = 0. → IDLE when ST=0 and `pc_kernel`=0 (handler cleared ST and returned to user mode).
- **Simultaneous events**
  - Bus write to TL in the same cycle as overflow: the written value wins. ST and OVC are not updated for that cycle's overflow.
  - Bus write to TH in the overflow cycle: TL reloads with the *old* TH; the new TH applies from the next overflow.
  - W1C of ST in the same cycle as a new overflow: set wins, ST = 1.
  - Write clearing EN in the overflow cycle: no reload, no ST set; TL holds 32'hFFFF_FFFF.
  - `irq_taken` while the FSM is not in PEND: ignored.

## Timing

- **Reset** (asynchronous, `reset`=0): TH=0, TL=0, TCON=0, OVC=0, `s`=IDLE, `irq`=0. `rdata`=0 while `rd`=0.
- **Write latency**: a write in cycle N is visible to a read and to the counter in cycle N+1.
- **Overflow to interrupt**, with TL = FFFF_FFFF in cycle N:
  - N+1: TL=TH, ST=1.
  - N+2: `s`=PEND, `irq`=1 if `pc_kernel`=0.
- **Request hold**: `irq` stays asserted until the cycle after `irq_taken`; it drops in that cycle (`s`=SERV).
- **Kernel-mode masking**: `pc_kernel`=1 masks `irq` combinationally in PEND; the request is not lost.
- **Reset mid-handshake**: any state returns to IDLE, and the pending ST is discarded.

## Test plan

- **Reload and interrupt**
  - Stimulus: TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3.
  - Required: TL=FFFF_FFFC two cycles after EN is seen; ST=1; OVC=1; `irq`=1 one cycle later.
- **Handshake**
  - Stimulus: in PEND, pulse `irq_taken`; hold `pc_kernel`=1; write TCON=32'h7; then drop `pc_kernel`.
  - Required: `irq` 0 from the next cycle; `s` returns to IDLE only after both ST=0 and `pc_kernel`=0; no re-assertion.
- **Kernel masking**
  - Stimulus: ST=1, IE=1, `pc_kernel`=1 for 10 cycles, then 0.
  - Required: `irq`=0 for those 10 cycles, then 1 in the same cycle `pc_kernel` falls.
- **Collisions**
  - Stimulus: write TL=5 in the overflow cycle; separately, W1C ST in a cycle with a new overflow.
  - Required: TL=5 with ST and OVC unchanged; in the second case ST=1.
- **Decode and reset**
  - Stimulus: read and write BASE+0x10 and 0x4000_0008 with the wrong upper bits; later, assert `reset` during PEND.
  - Required: address checks give `rdata`=0 and no register change. Reset gives `irq`=0 immediately and all registers 0.
